mac_operand_feeder: RTL

Upstream operand stage for the 4-bit signed MAC. Buffers signed operand pairs written by the host into a small FIFO. Once a full vector of VEC_LEN pairs is available, it streams the vector to the MAC on consecutive cycles, with both operand valids asserted together. It then waits for the MAC's result strobe before issuing the next vector, with a timeout that flags a stalled MAC.

---
 rtl/mac_operand_feeder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mac_operand_feeder.sv
// Operand feeder for the 4-bit signed MAC: buffers host pairs in a FIFO and
// streams one VEC_LEN-pair vector at a time, then waits for the MAC result.
module mac_operand_feeder #(
    parameter int VEC_LEN = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [3:0]               wr_a,
    input  logic [3:0]               wr_b,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [3:0]               in_a,
    output logic [3:0]               in_b,
    output logic                     in_valid_a,
    output logic                     in_valid_b,
    input  logic                     out_valid,
    output logic                     busy,
    output logic [7:0]               vec_cnt,
    output logic                     overflow,
    output logic                     timeout_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES} state_t;

    state_t          r_state, w_nextState;
    logic [7:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_wrPtr, r_rdPtr;
    logic [CW-1:0]   r_count, r_idx, w_countNext;
    logic [TW-1:0]   r_timer;
    logic            r_full, r_valid, r_overflow, r_timeoutErr;
    logic [3:0]      r_inA, r_inB;
    logic [7:0]      r_vecCnt;
    logic            w_push, w_pop, w_result, w_timeout;
    logic            w_vecReady, w_streamDone, w_timerDone;

    assign w_vecReady   = r_count >= CW'(VEC_LEN);
    assign w_streamDone = r_idx == CW'(VEC_LEN);
    assign w_timerDone  = r_timer == TW'(TIMEOUT - 1);
    assign w_push       = wr_en && !r_full;
    assign w_countNext  = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (w_vecReady) w_nextState = STREAM;
            STREAM:   if (w_streamDone) w_nextState = WAIT_RES;
            WAIT_RES: if (out_valid || w_timerDone) w_nextState = IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    // A result arriving on the timeout edge takes priority over the error.
    always_comb begin
        w_pop     = 1'b0;
        w_result  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE:     w_pop = w_vecReady;
            STREAM:   w_pop = !w_streamDone;
            WAIT_RES: begin
                w_result  = out_valid;
                w_timeout = !out_valid && w_timerDone;
            end
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) r_mem[r_wrPtr] <= {wr_a, wr_b};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_idx        <= '0;
            r_timer      <= '0;
            r_valid      <= 1'b0;
            r_inA        <= '0;
            r_inB        <= '0;
            r_vecCnt     <= '0;
            r_overflow   <= 1'b0;
            r_timeoutErr <= 1'b0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
            r_count <= w_countNext;
            r_full  <= w_countNext == CW'(DEPTH);
            if (wr_en && r_full) r_overflow <= 1'b1;

            r_valid <= w_pop;
            if (w_pop) begin
                {r_inA, r_inB} <= r_mem[r_rdPtr];
                r_idx          <= (r_state == IDLE) ? CW'(1) : r_idx + CW'(1);
            end

            r_timer <= (r_state == WAIT_RES) ? r_timer + TW'(1) : '0;
            if (w_result)  r_vecCnt     <= r_vecCnt + 8'd1;
            if (w_timeout) r_timeoutErr <= 1'b1;
        end
    end

    assign full        = r_full;
    assign count       = r_count;
    assign in_a        = r_inA;
    assign in_b        = r_inB;
    assign in_valid_a  = r_valid;
    assign in_valid_b  = r_valid;
    assign busy        = r_state != IDLE;
    assign vec_cnt     = r_vecCnt;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeoutErr;
endmodule
